// File: rtl/load_use_scoreboard_if.sv
// Interface bundling the ID-stage query, issue, writeback and stall-control
// signals of the load-use scoreboard. The pipeline side uses the master
// modport; the scoreboard itself uses the slave modport.
interface load_use_scoreboard_if #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
);
    // ID-stage source-register query
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;

    // Producer issue at the ID/EX boundary
    logic             issue_valid;
    logic [4:0]       issue_rd;

    // Producer writeback
    logic             wb_valid;
    logic [4:0]       wb_rd;

    // Pipeline squash
    logic             flush;

    // Stall controls and occupancy
    logic             stall;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic [CNT_W-1:0] outstanding;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output issue_valid, issue_rd, wb_valid, wb_rd, flush,
        input  stall, pc_write, ifid_write, idex_bubble, outstanding
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  issue_valid, issue_rd, wb_valid, wb_rd, flush,
        output stall, pc_write, ifid_write, idex_bubble, outstanding
    );
endinterface

// File: rtl/load_use_scoreboard.sv
// Load-use scoreboard: tracks destination registers of in-flight multi-cycle
// producers from issue until writeback. It answers ID-stage source queries and
// drives the stall / PC write / IF-ID write / ID-EX bubble controls.
// Register x0 is never tracked.
module load_use_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,   // 1..31
    parameter int WB_BYPASS       = 1    // 1: same-cycle writeback hides a pending reg
) (
    input  logic                  clk,
    input  logic                  rst_n,
    load_use_scoreboard_if.slave  bus
);

    localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // Architectural state: one pending bit per register plus occupancy count.
    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] count_q,   count_d;

    // Hazard evaluation signals
    logic [31:0]      wb_mask;
    logic [31:0]      eff_pending;
    logic             raw_hazard;
    logic             waw_hazard;
    logic             full_hazard;
    logic             stall;
    logic             rel_hit;
    logic             issue_ok;

    // Hazard detection: combinational from registered state and current inputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        wb_mask = '0;
        if (WB_BYPASS != 0 && bus.wb_valid) begin
            wb_mask[bus.wb_rd] = 1'b1;
        end
        eff_pending = pending_q & ~wb_mask;

        // A release needs the register to actually be pending; writebacks to
        // x0 or to untracked registers are ignored.
        rel_hit = bus.wb_valid && (bus.wb_rd != 5'd0) && pending_q[bus.wb_rd];

        raw_hazard = (bus.id_use_rs1 && (bus.id_rs1 != 5'd0) && eff_pending[bus.id_rs1])
                  || (bus.id_use_rs2 && (bus.id_rs2 != 5'd0) && eff_pending[bus.id_rs2]);

        waw_hazard = bus.issue_valid && (bus.issue_rd != 5'd0) && eff_pending[bus.issue_rd];

        // Table full only blocks when no slot frees up this same cycle.
        full_hazard = bus.issue_valid && (bus.issue_rd != 5'd0)
                   && (count_q == CNT_MAX) && !rel_hit;

        stall = raw_hazard || waw_hazard || full_hazard;

        issue_ok = bus.issue_valid && !stall && !bus.flush && (bus.issue_rd != 5'd0);
    end

    // Next-state: release clears before issue sets; flush overrides everything.
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;

        if (bus.flush) begin
            pending_d = '0;
            count_d   = '0;
        end else begin
            if (rel_hit) begin
                pending_d[bus.wb_rd] = 1'b0;
            end
            if (issue_ok) begin
                pending_d[bus.issue_rd] = 1'b1;
            end
            case ({issue_ok, rel_hit})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        pending_d[0] = 1'b0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        // The 32 pending bits are plain flops (not a RAM), so resetting them
        // is cheap and gives a clean, known scoreboard after reset.
        if (!rst_n) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    // Output drive
    assign bus.stall       = stall;
    assign bus.pc_write    = ~stall;
    assign bus.ifid_write  = ~stall;
    assign bus.idex_bubble = stall;
    assign bus.outstanding = count_q;

    // Structural invariants of the scoreboard state.
    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_MAX);
    a_count_match : assert property (@(posedge clk) disable iff (!rst_n)
        int'(count_q) == $countones(pending_q));
    a_x0_clear    : assert property (@(posedge clk) disable iff (!rst_n)
        pending_q[0] == 1'b0);

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench: drives identical stimulus into two scoreboards
// (WB_BYPASS=1 and WB_BYPASS=0) and compares both against a set-based
// reference model of pending destination registers.
module tb_load_use_scoreboard;

    localparam int MAXO  = 4;
    localparam int CNT_W = $clog2(MAXO + 1);

    logic clk;
    logic rst_n;

    logic [4:0] id_rs1, id_rs2, issue_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, issue_valid, wb_valid, flush;

    int n_cmp;
    int n_err;

    // Model: per instance (0 = bypass, 1 = no bypass) the set of pending regs.
    bit pend [2][32];

    load_use_scoreboard_if #(.MAX_OUTSTANDING(MAXO)) if_a ();
    load_use_scoreboard_if #(.MAX_OUTSTANDING(MAXO)) if_b ();

    assign if_a.id_rs1 = id_rs1;          assign if_b.id_rs1 = id_rs1;
    assign if_a.id_rs2 = id_rs2;          assign if_b.id_rs2 = id_rs2;
    assign if_a.id_use_rs1 = id_use_rs1;  assign if_b.id_use_rs1 = id_use_rs1;
    assign if_a.id_use_rs2 = id_use_rs2;  assign if_b.id_use_rs2 = id_use_rs2;
    assign if_a.issue_valid = issue_valid; assign if_b.issue_valid = issue_valid;
    assign if_a.issue_rd = issue_rd;      assign if_b.issue_rd = issue_rd;
    assign if_a.wb_valid = wb_valid;      assign if_b.wb_valid = wb_valid;
    assign if_a.wb_rd = wb_rd;            assign if_b.wb_rd = wb_rd;
    assign if_a.flush = flush;            assign if_b.flush = flush;

    load_use_scoreboard #(.MAX_OUTSTANDING(MAXO), .WB_BYPASS(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    load_use_scoreboard #(.MAX_OUTSTANDING(MAXO), .WB_BYPASS(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_count(input int k);
        int c = 0;
        for (int r = 0; r < 32; r++) if (pend[k][r]) c++;
        return c;
    endfunction

    // Is register r considered busy by a query in instance k this cycle?
    function automatic bit m_busy(input int k, input int r);
        if (r == 0) return 1'b0;
        if (k == 0 && wb_valid && int'(wb_rd) == r) return 1'b0;
        return pend[k][r];
    endfunction

    function automatic bit m_release(input int k);
        return wb_valid && wb_rd != 0 && pend[k][wb_rd];
    endfunction

    function automatic bit m_stall(input int k);
        bit raw, waw, full;
        raw  = (id_use_rs1 && m_busy(k, int'(id_rs1))) || (id_use_rs2 && m_busy(k, int'(id_rs2)));
        waw  = issue_valid && m_busy(k, int'(issue_rd));
        full = issue_valid && issue_rd != 0 && m_count(k) == MAXO && !m_release(k);
        return raw || waw || full;
    endfunction

    function automatic int obs_stall(input int k);
        return (k == 0) ? int'(if_a.stall) : int'(if_b.stall);
    endfunction

    function automatic int obs_count(input int k);
        return (k == 0) ? int'(if_a.outstanding) : int'(if_b.outstanding);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic iv, input logic [4:0] ird,
                         input logic wv, input logic [4:0] wrd, input logic fl);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_rd = wrd; flush = fl;
        #2;
    endtask

    task automatic compare_all();
        int s;
        for (int k = 0; k < 2; k++) begin
            s = int'(m_stall(k));
            check($sformatf("stall[%0d]", k), obs_stall(k), s);
            check($sformatf("outstanding[%0d]", k), obs_count(k), m_count(k));
            if (k == 0) begin
                check("pc_write[0]", int'(if_a.pc_write), 1 - s);
                check("ifid_write[0]", int'(if_a.ifid_write), 1 - s);
                check("idex_bubble[0]", int'(if_a.idex_bubble), s);
            end else begin
                check("pc_write[1]", int'(if_b.pc_write), 1 - s);
                check("ifid_write[1]", int'(if_b.ifid_write), 1 - s);
                check("idex_bubble[1]", int'(if_b.idex_bubble), s);
            end
        end
    endtask

    // Advance one clock and apply the scoreboard rules to the model.
    task automatic clock();
        bit acc [2];
        bit rel [2];
        for (int k = 0; k < 2; k++) begin
            acc[k] = issue_valid && !m_stall(k) && !flush && issue_rd != 0;
            rel[k] = m_release(k);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                for (int r = 0; r < 32; r++) pend[k][r] = 1'b0;
            end else begin
                if (rel[k]) pend[k][wb_rd] = 1'b0;
                if (acc[k]) pend[k][issue_rd] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2,
                        input logic iv, input logic [4:0] ird,
                        input logic wv, input logic [4:0] wrd, input logic fl);
        drive(rs1, rs2, u1, u2, iv, ird, wv, wrd, fl);
        compare_all();
        clock();
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) pend[k][r] = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stall_a"}, int'(if_a.stall), 0);
        check({tag, "_pcw_a"}, int'(if_a.pc_write), 1);
        check({tag, "_ifidw_a"}, int'(if_a.ifid_write), 1);
        check({tag, "_bubble_a"}, int'(if_a.idex_bubble), 0);
        check({tag, "_cnt_a"}, int'(if_a.outstanding), 0);
        check({tag, "_stall_b"}, int'(if_b.stall), 0);
        check({tag, "_cnt_b"}, int'(if_b.outstanding), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        model_clear();
        rst_n = 1'b0;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Issue x5, then query it.
        step(0, 0, 0, 0, 1, 5, 0, 0, 0);
        drive(5, 0, 1, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("q5_stall", int'(if_a.stall), 1);
        check("q5_pcw", int'(if_a.pc_write), 0);
        check("q5_bubble", int'(if_a.idex_bubble), 1);
        check("q5_cnt", int'(if_a.outstanding), 1);
        clock();

        // Writeback x5 while it is queried: bypass hides it, no-bypass stalls once.
        drive(5, 0, 1, 0, 0, 0, 1, 5, 0);
        compare_all();
        check("wb5_bypass_stall", int'(if_a.stall), 0);
        check("wb5_nobypass_stall", int'(if_b.stall), 1);
        clock();
        drive(5, 0, 1, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("wb5_after_stall_b", int'(if_b.stall), 0);
        check("wb5_after_cnt_b", int'(if_b.outstanding), 0);
        clock();

        // x0 is never tracked.
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
        compare_all();
        check("x0_stall", int'(if_a.stall), 0);
        check("x0_cnt", int'(if_a.outstanding), 0);
        clock();

        // Fill to MAX_OUTSTANDING, then overflow attempt, then swap with a release.
        for (int r = 1; r <= 4; r++) step(0, 0, 0, 0, 1, 5'(r), 0, 0, 0);
        drive(0, 0, 0, 0, 1, 6, 0, 0, 0);
        compare_all();
        check("full_stall", int'(if_a.stall), 1);
        check("full_cnt", int'(if_a.outstanding), 4);
        clock();
        step(0, 0, 0, 0, 1, 6, 1, 1, 0);
        drive(6, 1, 1, 1, 0, 0, 0, 0, 0);
        compare_all();
        check("swap_cnt", int'(if_a.outstanding), 4);
        check("swap_q6_stall", int'(if_a.stall), 1);
        clock();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("swap_q1_stall", int'(if_a.stall), 0);
        clock();

        // Flush with same-cycle issue and wb.
        step(0, 0, 0, 0, 1, 10, 1, 3, 1);
        drive(10, 2, 1, 1, 0, 0, 0, 0, 0);
        compare_all();
        check("flush_cnt", int'(if_a.outstanding), 0);
        check("flush_stall", int'(if_a.stall), 0);
        clock();

        // WAW on x7, ignored wb to a non-pending register.
        step(0, 0, 0, 0, 1, 7, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 7, 0, 0, 0);
        compare_all();
        check("waw_stall_b", int'(if_b.stall), 1);
        clock();
        step(0, 0, 0, 0, 0, 0, 1, 9, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        compare_all();
        check("wb9_cnt", int'(if_a.outstanding), 1);
        clock();

        // Randomized traffic with a mid-run asynchronous reset.
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) begin
                // Make sure something is pending so the reset has work to do.
                step(0, 0, 0, 0, 1, 12, 0, 0, 0);
                rst_n = 1'b0;
                #1;
                check_reset_values("async_rst");
                model_clear();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)),
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 9)),
                 1'($urandom_range(0, 40) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Producer-side companion to the combinational load-use hazard check.
- Tracks destination registers of in-flight multi-cycle producers (loads, long-latency ops) from issue until writeback.
- Answers ID-stage source-register queries and drives stall, PC write-enable, IF/ID write-enable and ID/EX bubble.
- Sits between the ID/EX boundary (issue) and the WB stage (release).

Parameters:
- MAX_OUTSTANDING, 4, maximum simultaneously pending producers; issue stalls when reached (1..31).
- WB_BYPASS, 1, 1 = a same-cycle writeback of a queried register does not cause a stall; 0 = it stalls one more cycle.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_rs1  input  5  ID-stage source register 1.
- id_rs2  input  5  ID-stage source register 2.
- id_use_rs1  input  1  instruction in ID reads rs1.
- id_use_rs2  input  1  instruction in ID reads rs2.
- issue_valid  input  1  instruction in ID is a tracked producer and wants to issue.
- issue_rd  input  5  destination of the issuing producer.
- wb_valid  input  1  tracked producer writing back this cycle.
- wb_rd  input  5  destination being written back.
- flush  input  1  squash: clear all tracking.
- stall  output  1  hold ID, insert bubble.
- pc_write  output  1  equals ~stall.
- ifid_write  output  1  equals ~stall.
- idex_bubble  output  1  equals stall.
- outstanding  output  $clog2(MAX_OUTSTANDING+1)  count of pending registers.

Behaviour:
- State: pending[31:0] (bit 0 hardwired 0) and the outstanding counter. Reset (async, rst_n low) clears both: stall=0, pc_write=1, ifid_write=1, idex_bubble=0, outstanding=0.
- Effective pending mask for queries: eff = pending & ~(WB_BYPASS && wb_valid ? onehot(wb_rd) : 0).
- Hazard sources:
  - raw = (id_use_rs1 && id_rs1!=0 && eff[id_rs1]) || (id_use_rs2 && id_rs2!=0 && eff[id_rs2]).
  - waw = issue_valid && issue_rd!=0 && eff[issue_rd].
  - full = issue_valid && issue_rd!=0 && outstanding==MAX_OUTSTANDING, with no same-cycle wb release.
- stall = raw | waw | full. It is combinational from registered state and current inputs; zero added latency.
- Issue accepted when issue_valid && !stall && !flush && issue_rd!=0. Effect at the next edge: pending[issue_rd] set, count+1. issue_rd=0 is never tracked.
- Release when wb_valid && pending[wb_rd] && wb_rd!=0. Effect at the next edge: pending[wb_rd] cleared, count-1. A wb to a non-pending register or x0 is ignored; count unchanged.
- Accepted issue and release on the same cycle, different rd: both apply, count unchanged.
- Same rd on issue and release: the release clears, then the issue sets (bit ends set), count unchanged. This case is reachable only with WB_BYPASS=1.
- flush has top priority: next edge clears all pending and sets count=0. Same-cycle issue and wb are dropped. stall is still computed normally during the flush cycle.
- Count never exceeds MAX_OUTSTANDING and never underflows; this is guaranteed by the rules above.
- Reset mid-operation clears all state immediately (asynchronous); outputs return to reset values without waiting for a clock.

Test Plan:
- Reset → all outputs at reset values; issue rd=5, next cycle query rs1=5 use=1 → stall=1, pc_write=0, ifid_write=0, idex_bubble=1, outstanding=1.
- pending x5; wb_valid rd=5 with rs1=5 queried same cycle → WB_BYPASS=1: stall=0; WB_BYPASS=0: stall=1 this cycle, 0 next; outstanding→0.
- Issue rd=0, then query rs1=0 → never pending, stall=0, outstanding=0.
- MAX_OUTSTANDING=4: issue rd 1,2,3,4 → outstanding=4; issue rd=6 → stall=1, not accepted. Same cycle add wb rd=1 → accepted, outstanding stays 4, pending {2,3,4,6}.
- pending x7; issue rd=7 with WB_BYPASS=0 → stall (WAW). wb rd=9 (not pending) → ignored, count unchanged.
- pending {3,8}; flush with issue rd=10 and wb rd=3 same cycle → next cycle pending empty, outstanding=0. Assert rst_n low mid-sequence → outputs reset asynchronously.
